// File: rtl/mdu_unit.sv
// mdu_unit: E-stage multiply/divide unit holding architectural HI/LO.
// Results are computed when an operation is accepted and parked in hi_t/lo_t.
// busy then stays high for a fixed cycle count, after which they are committed.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  mdu_op,
  input  logic        start,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        req,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state;
  op_t           op;
  logic [CW-1:0] cnt;
  logic [31:0]   hi_t;
  logic [31:0]   lo_t;

  logic [63:0] prod;
  logic [31:0] div_a, div_b, uq, ur;
  logic        is_mul, is_div, sgn_div;
  logic [31:0] res_hi, res_lo;

  assign op   = op_t'(mdu_op);
  assign busy = (state == RUN);

  // Result datapath. Signed divide goes through magnitudes so that
  // 0x80000000 / -1 wraps to 0x80000000 with remainder 0 without overflow.
  always_comb begin
    is_mul  = (op == OP_MULT) || (op == OP_MULTU);
    is_div  = (op == OP_DIV)  || (op == OP_DIVU);
    sgn_div = (op == OP_DIV);
    if (op == OP_MULT)
      prod = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    else
      prod = {32'd0, rs_val} * {32'd0, rt_val};
    div_a = (sgn_div && rs_val[31]) ? (32'd0 - rs_val) : rs_val;
    div_b = (sgn_div && rt_val[31]) ? (32'd0 - rt_val) : rt_val;
    if (div_b == '0) begin
      uq = '0;
      ur = '0;
    end else begin
      uq = div_a / div_b;
      ur = div_a % div_b;
    end
    res_hi = hi;
    res_lo = lo;
    if (is_mul) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end else if (is_div && (rt_val != '0)) begin
      res_lo = (sgn_div && (rs_val[31] ^ rt_val[31])) ? (32'd0 - uq) : uq;
      res_hi = (sgn_div && rs_val[31]) ? (32'd0 - ur) : ur;
    end
  end

  // Control FSM plus HI/LO and staging registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      hi_t  <= '0;
      lo_t  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!req) begin
            if (start && (is_mul || is_div)) begin
              hi_t  <= res_hi;
              lo_t  <= res_lo;
              cnt   <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
              state <= RUN;
            end
            if (op == OP_MTHI) hi <= rs_val;
            if (op == OP_MTLO) lo <= rs_val;
          end
        end
        RUN: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            hi    <= hi_t;
            lo    <= lo_t;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed and randomized checks of mdu_unit against an
// arithmetic reference model of HI/LO and busy timing.
module tb_mdu_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  mdu_op;
  logic        start;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        req;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk    (clk),
    .reset  (reset),
    .mdu_op (mdu_op),
    .start  (start),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .req    (req),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: what an accepted op 1..4 will leave in HI/LO, and for how long busy is up.
  task automatic ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n, output logic [31:0] nh, output logic [31:0] nl);
    int              ia, ib;
    longint          sa, sb, p, q, r;
    longint unsigned ua, ub, up;
    ia = a; ib = b;
    sa = ia; sb = ib;
    ua = a;  ub = b;
    n  = 0;
    nh = m_hi;
    nl = m_lo;
    case (op)
      3'd1: begin p = sa * sb; nh = p[63:32]; nl = p[31:0]; n = MC; end
      3'd2: begin up = ua * ub; nh = up[63:32]; nl = up[31:0]; n = MC; end
      3'd3: begin
        n = DC;
        if (b != 0) begin q = sa / sb; r = sa % sb; nl = q[31:0]; nh = r[31:0]; end
      end
      3'd4: begin
        n = DC;
        if (b != 0) begin up = ua / ub; nl = up[31:0]; up = ua % ub; nh = up[31:0]; end
      end
      default: n = 0;
    endcase
  endtask

  task automatic clear_inputs();
    mdu_op = '0; start = 1'b0; rs_val = '0; rt_val = '0; req = 1'b0;
  endtask

  // Present one request for one cycle and check busy/HI/LO until the unit is idle again.
  task automatic do_op(input logic [2:0] op, input logic st, input logic [31:0] a,
                       input logic [31:0] b, input logic r);
    int          n, inj;
    logic [31:0] nh, nl;
    @(negedge clk);
    ref_op(op, a, b, n, nh, nl);
    if (!(st && !r)) n = 0;
    mdu_op = op; start = st; rs_val = a; rt_val = b; req = r;
    @(negedge clk);
    clear_inputs();
    if (n == 0) begin
      if (!r && op == 3'd5) m_hi = a;
      if (!r && op == 3'd6) m_lo = a;
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_hi", hi, m_hi);
      check("idle_lo", lo, m_lo);
    end else begin
      inj = $urandom_range(0, n - 1);
      for (int i = 0; i < n; i++) begin
        check("run_busy", {31'd0, busy}, 32'd1);
        check("run_hi", hi, m_hi);
        check("run_lo", lo, m_lo);
        if (i == inj) begin
          mdu_op = 3'($urandom_range(0, 7)); start = 1'b1;
          rs_val = $urandom; rt_val = $urandom; req = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        clear_inputs();
      end
      m_hi = nh;
      m_lo = nl;
      check("done_busy", {31'd0, busy}, 32'd0);
      check("done_hi", hi, m_hi);
      check("done_lo", lo, m_lo);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    clear_inputs();
    reset = 1'b1;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    do_op(3'd1, 1'b1, 32'hFFFF_FFFD, 32'd7, 1'b0);
    check("mult_hi_const", hi, 32'hFFFF_FFFF);
    check("mult_lo_const", lo, 32'hFFFF_FFEB);
    do_op(3'd2, 1'b1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    check("multu_hi_const", hi, 32'h0000_0001);
    check("multu_lo_const", lo, 32'hFFFF_FFFE);
    do_op(3'd3, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_lo_const", lo, 32'hFFFF_FFFD);
    check("div_hi_const", hi, 32'hFFFF_FFFF);
    do_op(3'd3, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("divovf_lo_const", lo, 32'h8000_0000);
    check("divovf_hi_const", hi, 32'h0000_0000);
    do_op(3'd5, 1'b0, 32'h0000_1234, 32'd0, 1'b0);
    do_op(3'd4, 1'b1, 32'd99, 32'd0, 1'b0);
    check("divu0_hi_const", hi, 32'h0000_1234);
    check("divu0_lo_const", lo, 32'h8000_0000);
    do_op(3'd1, 1'b1, 32'd3, 32'd4, 1'b1);
    do_op(3'd6, 1'b0, 32'hDEAD_BEEF, 32'd0, 1'b1);
    do_op(3'd6, 1'b1, 32'hCAFE_0001, 32'd0, 1'b0);
    do_op(3'd0, 1'b1, 32'd5, 32'd6, 1'b0);
    do_op(3'd7, 1'b1, 32'd5, 32'd6, 1'b0);

    // Reset in the middle of a divide.
    @(negedge clk);
    mdu_op = 3'd3; start = 1'b1; rs_val = 32'd100; rt_val = 32'd7;
    @(negedge clk);
    clear_inputs();
    repeat (3) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    do_op(3'd1, 1'b1, 32'd6, 32'hFFFF_FFFF, 1'b0);
    check("postrst_lo_const", lo, 32'hFFFF_FFFA);

    for (int k = 0; k < 60; k++) begin
      do_op(3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0), pick_operand(),
            pick_operand(), ($urandom_range(0, 4) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
